// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, constants and lane helper for the MEM-stage
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_RD   = 3'd1,
      LD_CAP  = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_CAP = 3'd5,
      RMW_WR  = 3'd6
   } state_e;

   // Bit position of the lowest byte of a lane selected by byte offset
   // (little-endian: offset 0 is bits [7:0]).
   function automatic logic [4:0] lane_shift(input logic [1:0] offset);
      return {offset, 3'b000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Combinational byte-lane logic shared by the load path
//               (extract + extend) and the read-modify-write store path
//               (merge new lane(s) into the memory word).
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] mem_word,
   input  logic [1:0]        offset,
   input  size_e             size,
   input  logic              sext,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] merged
);

   logic [DATA_W-1:0] w_shifted;
   logic [DATA_W-1:0] w_mask;
   logic [DATA_W-1:0] w_ins;

   // Load path: bring the addressed lane down to bit 0 and extend it.
   always_comb begin
      w_shifted = mem_word >> lane_shift(offset);
      case (size)
         SZ_B:    rdata = {{(DATA_W-8){sext & w_shifted[7]}}, w_shifted[7:0]};
         SZ_H:    rdata = {{(DATA_W-16){sext & w_shifted[15]}}, w_shifted[15:0]};
         default: rdata = w_shifted;
      endcase
   end

   // Store path: replace only the addressed lane(s) of the old word.
   always_comb begin
      case (size)
         SZ_B: begin
            w_mask = {{(DATA_W-8){1'b0}}, 8'hFF} << lane_shift(offset);
            w_ins  = {{(DATA_W-8){1'b0}}, wdata[7:0]} << lane_shift(offset);
         end
         SZ_H: begin
            w_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF} << lane_shift(offset);
            w_ins  = {{(DATA_W-16){1'b0}}, wdata[15:0]} << lane_shift(offset);
         end
         default: begin
            w_mask = '1;
            w_ins  = wdata;
         end
      endcase
      merged = (mem_word & ~w_mask) | (w_ins & w_mask);
   end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : MEM-stage load/store unit in front of a word-wide data
//               memory. Byte/half stores use read-modify-write. Every
//               output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
   import lsu_pkg::*;
#(
   parameter int          DATA_W   = DATA_W_DEF,
   parameter int          DM_AW    = 10,
   parameter int unsigned DM_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sext,
   input  logic [DM_AW+1:0]  req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              DM_read,
   output logic              DM_write,
   output logic [DM_AW-1:0]  DM_addr,
   output logic [DATA_W-1:0] DM_in,
   input  logic [DATA_W-1:0] DM_out
);

   state_e            r_state;
   state_e            w_state_nx;

   // Request fields latched at acceptance
   logic [1:0]        r_offset;
   size_e             r_size;
   logic              r_sext;
   logic [DATA_W-1:0] r_wdata;

   size_e             w_req_size;
   logic              w_accept;
   logic              w_bad;
   logic [31:0]       w_waddr_ext;

   logic [DATA_W-1:0] w_ld_data;
   logic [DATA_W-1:0] w_merged;

   logic              w_ready_nx;
   logic              w_rv_nx;
   logic              w_err_nx;
   logic [DATA_W-1:0] w_rdata_nx;
   logic              w_rd_nx;
   logic              w_wr_nx;
   logic [DM_AW-1:0]  w_addr_nx;
   logic [DATA_W-1:0] w_din_nx;

   // Acceptance decode: reserved size, misalignment, then word range.
   always_comb begin
      w_req_size  = size_e'(req_size);
      w_accept    = req_valid && req_ready;
      w_waddr_ext = 32'(req_addr[DM_AW+1:2]);
      w_bad       = (w_req_size == SZ_RSV)
                 || (w_req_size == SZ_H && req_addr[0])
                 || (w_req_size == SZ_W && req_addr[1:0] != 2'b00)
                 || (w_waddr_ext >= DM_WORDS);
   end

   lsu_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .mem_word (DM_out),
      .offset   (r_offset),
      .size     (r_size),
      .sext     (r_sext),
      .wdata    (r_wdata),
      .rdata    (w_ld_data),
      .merged   (w_merged)
   );

   // Latch the request so later input changes cannot disturb the operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_offset <= 2'b00;
         r_size   <= SZ_B;
         r_sext   <= 1'b0;
         r_wdata  <= '0;
      end else if (w_accept && !w_bad) begin
         r_offset <= req_addr[1:0];
         r_size   <= w_req_size;
         r_sext   <= req_sext;
         r_wdata  <= req_wdata;
      end
   end

   // Next state and next values of all registered outputs.
   always_comb begin
      w_state_nx = r_state;
      w_rv_nx    = 1'b0;
      w_err_nx   = 1'b0;
      w_rdata_nx = '0;
      w_rd_nx    = 1'b0;
      w_wr_nx    = 1'b0;
      w_addr_nx  = DM_addr;
      w_din_nx   = '0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               if (w_bad) begin
                  w_rv_nx  = 1'b1;
                  w_err_nx = 1'b1;
               end else begin
                  w_addr_nx = req_addr[DM_AW+1:2];
                  if (!req_we) begin
                     w_state_nx = LD_RD;
                     w_rd_nx    = 1'b1;
                  end else if (w_req_size == SZ_W) begin
                     w_state_nx = ST_WR;
                     w_wr_nx    = 1'b1;
                     w_din_nx   = req_wdata;
                  end else begin
                     w_state_nx = RMW_RD;
                     w_rd_nx    = 1'b1;
                  end
               end
            end
         end
         LD_RD:   w_state_nx = LD_CAP;
         LD_CAP: begin
            // DM_out holds the word read in LD_RD only during this cycle
            w_state_nx = IDLE;
            w_rv_nx    = 1'b1;
            w_rdata_nx = w_ld_data;
         end
         ST_WR: begin
            w_state_nx = IDLE;
            w_rv_nx    = 1'b1;
         end
         RMW_RD:  w_state_nx = RMW_CAP;
         RMW_CAP: begin
            w_state_nx = RMW_WR;
            w_wr_nx    = 1'b1;
            w_din_nx   = w_merged;
         end
         RMW_WR: begin
            w_state_nx = IDLE;
            w_rv_nx    = 1'b1;
         end
         default: w_state_nx = IDLE;
      endcase
      w_ready_nx = (w_state_nx == IDLE);
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         DM_read    <= 1'b0;
         DM_write   <= 1'b0;
         DM_addr    <= '0;
         DM_in      <= '0;
      end else begin
         r_state    <= w_state_nx;
         req_ready  <= w_ready_nx;
         resp_valid <= w_rv_nx;
         resp_err   <= w_err_nx;
         resp_rdata <= w_rdata_nx;
         DM_read    <= w_rd_nx;
         DM_write   <= w_wr_nx;
         DM_addr    <= w_addr_nx;
         DM_in      <= w_din_nx;
      end
   end

   a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
      !(DM_read && DM_write));

   // A write strobe can only come from an accepted request or the RMW merge.
   a_wr_origin: assert property (@(posedge clk) disable iff (rst)
      DM_write |-> (($past(r_state) == RMW_CAP) ||
                    ($past(r_state) == IDLE && $past(req_valid))));

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu with a byte-level reference
//               memory and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;

   localparam int DATA_W = 32;
   localparam int DM_AW  = 10;
   localparam int WORDS  = 768;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sext;
   logic [DM_AW+1:0]  req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [DATA_W-1:0] resp_rdata;
   logic              DM_read;
   logic              DM_write;
   logic [DM_AW-1:0]  DM_addr;
   logic [DATA_W-1:0] DM_in;
   logic [DATA_W-1:0] DM_out;

   mem_lsu #(
      .DATA_W   (DATA_W),
      .DM_AW    (DM_AW),
      .DM_WORDS (WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_sext   (req_sext),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .DM_read    (DM_read),
      .DM_write   (DM_write),
      .DM_addr    (DM_addr),
      .DM_in      (DM_in),
      .DM_out     (DM_out)
   );

   always #5 clk = ~clk;

   // Data memory: one-cycle read, output zero when not reading
   logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
   always @(posedge clk) begin
      if (DM_write) tb_mem[DM_addr] <= DM_in;
      if (DM_read) DM_out <= tb_mem[DM_addr];
      else         DM_out <= '0;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: byte-addressed memory and expected transaction events
   typedef struct {
      int          acc;
      int          rd_cyc;
      int          wr_cyc;
      int          resp_cyc;
      bit          err;
      logic [31:0] rdata;
      logic [9:0]  waddr;
      logic [31:0] wdata;
   } txn_t;

   logic [7:0] ref_mem [0:WORDS*4-1];
   txn_t       q[$];

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   logic [31:0] last_rdata, last_din;
   logic [9:0]  last_wa;
   logic        last_err;
   int          rd_cnt, wr_cnt, lo_cnt, rv_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit m_ready(input int c);
      foreach (q[i]) if (q[i].acc <= c && q[i].resp_cyc > c) return 1'b0;
      return 1'b1;
   endfunction

   // Per-cycle compare of every DUT output against the model's events
   initial begin
      bit          e_rd, e_wr, e_rv, e_err, e_rdy;
      logic [31:0] e_rdata, e_din;
      logic [9:0]  e_addr;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (DM_read)    rd_cnt++;
            if (DM_write)   begin wr_cnt++; last_din = DM_in; last_wa = DM_addr; end
            if (!req_ready) lo_cnt++;
            if (resp_valid) begin rv_cnt++; last_rdata = resp_rdata; last_err = resp_err; end
         end
         if (chk_en) begin
            e_rd = 0; e_wr = 0; e_rv = 0; e_err = 0; e_rdy = 1;
            e_rdata = '0; e_din = '0; e_addr = '0;
            foreach (q[i]) begin
               if (q[i].acc <= cyc && q[i].resp_cyc > cyc) e_rdy = 0;
               if (q[i].rd_cyc == cyc) begin e_rd = 1; e_addr = q[i].waddr; end
               if (q[i].wr_cyc == cyc) begin e_wr = 1; e_addr = q[i].waddr; e_din = q[i].wdata; end
               if (q[i].resp_cyc == cyc) begin e_rv = 1; e_err = q[i].err; e_rdata = q[i].rdata; end
            end
            chk("req_ready", req_ready, e_rdy);
            chk("DM_read", DM_read, e_rd);
            chk("DM_write", DM_write, e_wr);
            chk("rd_wr_exclusive", DM_read & DM_write, 0);
            if (e_rd || e_wr) chk("DM_addr", DM_addr, e_addr);
            if (e_wr) chk("DM_in", DM_in, e_din);
            chk("resp_valid", resp_valid, e_rv);
            if (e_rv) begin
               chk("resp_err", resp_err, e_err);
               chk("resp_rdata", resp_rdata, e_rdata);
            end
            while (q.size() > 0 && q[0].resp_cyc <= cyc) void'(q.pop_front());
         end
      end
   end

   // Present one request; acceptance happens on the next edge the model is ready.
   task automatic do_req(input bit we, input logic [1:0] sz, input bit sx,
                         input logic [11:0] addr, input logic [31:0] wd);
      txn_t        t;
      int          n, a, base, waits;
      logic [63:0] v;
      req_valid = 1; req_we = we; req_size = sz; req_sext = sx;
      req_addr = addr; req_wdata = wd;
      waits = 0;
      while (!m_ready(cyc)) begin
         @(posedge clk); #2;
         waits++;
         if (waits > 50) begin
            n_bad++;
            $display("FAIL accept_timeout: got busy expected ready (cycle %0d)", cyc);
            return;
         end
      end
      a = int'(addr);
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      t.acc = cyc + 1; t.rd_cyc = -1; t.wr_cyc = -1; t.err = 0;
      t.rdata = '0; t.wdata = '0; t.waddr = addr[11:2];
      if (sz == 2'b11 || (a % n) != 0 || a / 4 >= WORDS) begin
         t.err = 1; t.resp_cyc = t.acc;
      end else if (!we) begin
         v = '0;
         for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a+i]) << (8*i));
         if (sx && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
         t.rdata = v[31:0]; t.rd_cyc = t.acc; t.resp_cyc = t.acc + 2;
      end else begin
         for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(wd >> (8*i));
         base = a - (a % 4);
         t.wdata = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
         if (n == 4) begin
            t.wr_cyc = t.acc; t.resp_cyc = t.acc + 1;
         end else begin
            t.rd_cyc = t.acc; t.wr_cyc = t.acc + 2; t.resp_cyc = t.acc + 3;
         end
      end
      q.push_back(t);
      @(posedge clk); #2;
   endtask

   task automatic idle(input int n);
      req_valid = 0;
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic one(input bit we, input logic [1:0] sz, input bit sx,
                      input logic [11:0] addr, input logic [31:0] wd);
      do_req(we, sz, sx, addr, wd);
      idle(5);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_err"}, resp_err, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_DM_read"}, DM_read, 0);
      chk({tag, "_DM_write"}, DM_write, 0);
      chk({tag, "_DM_addr"}, DM_addr, 0);
      chk({tag, "_DM_in"}, DM_in, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] saved [0:3];
      for (int i = 0; i < WORDS*4; i++) ref_mem[i] = 8'h00;
      rd_cnt = 0; wr_cnt = 0; lo_cnt = 0; rv_cnt = 0;
      last_rdata = '0; last_din = '0; last_wa = '0; last_err = 0;
      rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_sext = 0;
      req_addr = '0; req_wdata = '0;
      repeat (2) @(posedge clk);
      #2;
      chk_reset_outputs("reset");
      rst = 0;
      @(posedge clk); #2;
      chk_en = 1;

      // Word store then word load
      one(1, 2'b10, 0, 12'h010, 32'hDEADBEEF);
      chk("wst_din", last_din, 32'hDEADBEEF);
      chk("wst_addr", last_wa, 4);
      one(0, 2'b10, 0, 12'h010, 32'h0);
      chk("wld_data", last_rdata, 32'hDEADBEEF);

      // Byte store (RMW) and byte loads
      one(1, 2'b00, 0, 12'h011, 32'hFFFFFFA5);
      chk("bst_din", last_din, 32'hDEADA5EF);
      one(0, 2'b00, 1, 12'h011, 32'h0);
      chk("lb_signed", last_rdata, 32'hFFFFFFA5);
      one(0, 2'b00, 0, 12'h011, 32'h0);
      chk("lb_unsigned", last_rdata, 32'h000000A5);

      // Half store and mixed loads
      one(1, 2'b01, 0, 12'h012, 32'h00001234);
      chk("hst_din", last_din, 32'h1234A5EF);
      one(0, 2'b01, 1, 12'h012, 32'h0);
      chk("lh_signed_pos", last_rdata, 32'h00001234);
      one(0, 2'b00, 1, 12'h013, 32'h0);
      chk("lb_signed_pos", last_rdata, 32'h00000012);
      one(0, 2'b01, 1, 12'h010, 32'h0);
      chk("lh_signed_neg", last_rdata, 32'hFFFFA5EF);
      one(0, 2'b00, 1, 12'h010, 32'h0);
      chk("lb_lane0_neg", last_rdata, 32'hFFFFFFEF);

      // Highest in-range word
      one(1, 2'b10, 0, 12'hBFC, 32'hCAFEF00D);
      chk("top_word_addr", last_wa, 10'h2FF);
      one(0, 2'b10, 0, 12'hBFC, 32'h0);
      chk("top_word_data", last_rdata, 32'hCAFEF00D);

      // Error cases: no memory traffic at all
      rd_cnt = 0; wr_cnt = 0;
      last_err = 0; last_rdata = '1;
      one(0, 2'b01, 1, 12'h013, 32'h0);
      chk("err_half_mis", last_err, 1);
      chk("err_half_rdata", last_rdata, 0);
      last_err = 0; last_rdata = '1;
      one(1, 2'b10, 0, 12'h012, 32'h55555555);
      chk("err_word_mis", last_err, 1);
      chk("err_word_rdata", last_rdata, 0);
      last_err = 0;
      one(0, 2'b11, 0, 12'h010, 32'h0);
      chk("err_rsv_size", last_err, 1);
      last_err = 0;
      one(0, 2'b10, 0, 12'hC00, 32'h0);
      chk("err_range", last_err, 1);
      chk("err_no_read", rd_cnt, 0);
      chk("err_no_write", wr_cnt, 0);

      // Back-to-back loads with req_valid held high
      lo_cnt = 0;
      do_req(0, 2'b10, 0, 12'h010, 32'h0);
      do_req(0, 2'b00, 0, 12'h012, 32'h0);
      chk("b2b_ready_low", lo_cnt, 2);
      idle(5);
      chk("b2b_second", last_rdata, 32'h00000034);

      // Reset in RMW_CAP of a byte store to word 0
      for (int i = 0; i < 4; i++) saved[i] = ref_mem[i];
      do_req(1, 2'b00, 0, 12'h001, 32'h00000077);
      req_valid = 0;
      @(posedge clk); #2;
      chk_en = 0; rst = 1; wr_cnt = 0;
      #1;
      chk_reset_outputs("rst_mid");
      q.delete();
      for (int i = 0; i < 4; i++) ref_mem[i] = saved[i];
      @(posedge clk); #2;
      rst = 0;
      @(posedge clk); #2;
      chk_reset_outputs("rst_post");
      chk_en = 1;
      idle(3);
      chk("rst_no_write", wr_cnt, 0);
      last_rdata = '1; rv_cnt = 0;
      one(0, 2'b10, 0, 12'h000, 32'h0);
      chk("ld_after_rst", last_rdata, 0);
      chk("ld_after_rst_pulses", rv_cnt, 1);
      chk("mem_word4", tb_mem[4], 32'h1234A5EF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit in the MEM stage, directly upstream of the word-wide data memory.
- Accepts byte-addressed load/store requests from the EX/MEM pipeline register and drives the data memory's read/write/address/data pins.
- Returns load data, byte-aligned and sign- or zero-extended, to MEM/WB.
- Byte and halfword stores use read-modify-write, because the data memory only writes whole words.

Parameters:
- DATA_W, 32, register/word width; must equal the data memory word width.
- DM_AW, 10, word-address width; byte address width is DM_AW+2.
- DM_WORDS, 1024, implemented word count; word addresses at or above this value are out of range.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a clock edge where req_valid & req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_sext  in  1  loads only: 1 sign-extend, 0 zero-extend
- req_addr  in  DM_AW+2  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  qualified by resp_valid: misaligned, out-of-range or reserved size
- resp_rdata  out  DATA_W  load result, qualified by resp_valid; 0 for stores and errors
- DM_read  out  1  memory read strobe
- DM_write  out  1  memory write strobe
- DM_addr  out  DM_AW  word address (req_addr[DM_AW+1:2])
- DM_in  out  DATA_W  write word
- DM_out  in  DATA_W  memory read data; valid the cycle after a DM_read cycle

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. Any in-flight operation is abandoned; no DM_write is issued afterwards.
- All outputs are registered.
- Memory contract:
  - DM_read and DM_write are never high together.
  - DM_out is sampled exactly one edge after the DM_read cycle.
  - The memory zeroes DM_out on idle cycles, so DM_out is not sampled at any other time.
- req_ready is 1 only in IDLE.
- Acceptance checks, in priority order:
  - size=11 → error
  - half with addr[0]≠0 → error
  - word with addr[1:0]≠0 → error
  - word address ≥ DM_WORDS → error
- Error response: resp_valid=1 and resp_err=1 in the cycle after acceptance. No memory access. State stays IDLE.
- States: IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_CAP, RMW_WR.
- Load:
  - Accept → LD_RD (DM_read=1) → LD_CAP (DM_read=0).
  - At the LD_CAP→IDLE edge, capture DM_out, select the lane by addr[1:0] (little-endian) and extend per req_sext.
  - resp_valid high 2 cycles after acceptance; latency 3 edges to data.
- Word store:
  - Accept → ST_WR (DM_write=1, DM_in=req_wdata) → IDLE.
  - resp_valid in the cycle after ST_WR.
- Byte/half store:
  - Accept → RMW_RD (DM_read=1) → RMW_CAP → RMW_WR (DM_write=1).
  - Merged word = DM_out with the target lane(s) replaced by req_wdata[7:0] / [15:0] at byte offset addr[1:0].
  - RMW_WR → IDLE with a resp_valid pulse.
- Request fields (addr, size, sext, wdata) are latched at acceptance. Input changes while busy are ignored.
- resp_valid is never high for two consecutive cycles from the same request.
- A new request may be accepted in the same cycle resp_valid is high, because the unit is already back in IDLE.
- Assertions:
  - !(DM_read && DM_write)
  - DM_write never follows reset without a new acceptance

Decomposition:
- Package lsu_pkg:
  - size_e {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10, SZ_RSV=2'b11}
  - state_e enumeration
  - DATA_W default constant
  - Lane-index helper function
- Sub-module lsu_lane_align (combinational), shared by the load and RMW paths:
  - extract + extend: DM_out, offset, size, sext → rdata
  - merge: DM_out, wdata, offset, size → merged word
- mem_lsu holds the FSM, request latch and output registers.

Test Plan:
- Word store 0xDEADBEEF @0x010, then word load @0x010:
  - store: DM_write for one cycle with DM_addr=4, DM_in=0xDEADBEEF; resp_valid 1 cycle after accept
  - load: resp_rdata=0xDEADBEEF, 2 cycles after accept
- Byte store 0xA5 @0x011, then loads:
  - DM_read then DM_write; DM_in=0xDEADA5EF
  - signed byte load @0x011 → 0xFFFFFFA5; unsigned → 0x000000A5
- Half store 0x1234 @0x012 → DM_in=0x1234A5EF; signed half load @0x012 → 0x00001234; signed byte load @0x013 → 0x00000012.
- Errors: half @0x013, word @0x012, size=11, word @(DM_WORDS*4) → each gives resp_err=1 the next cycle, resp_rdata=0, and no DM_read/DM_write for the whole test.
- req_valid held high with two loads back-to-back → req_ready low for 2 cycles; second accepted on the same cycle as the first resp_valid.
- rst pulsed during RMW_CAP of a byte store → DM_write never asserts, all outputs 0, req_ready=1; a following word load @0 returns 0.
